alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
- Multicycle issue/writeback controller on the driving side of the 16-bit ALU.
- Accepts instruction words over a valid/ready handshake and reads operands from an internal 16x16 register file.
- Drives the ALU's 6-bit opcode and A/B operands, captures the ALU result, and writes it back.
- Left shifts (SHIFTL) and right shifts (SHIFTR) by N are built from N single-bit ALU shift cycles. Zero and negative flags are maintained.

Parameters:
- NREGS, 16, number of registers (address width log2 = 4; only 16 supported).
- WIDTH, 16, datapath width; must match the ALU.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- instr_valid  in  1  instruction offered
- instr  in  16  [15:10] opcode, [9:6] rd, [5:2] rs, [1:0] reserved (ignored)
- instr_ready  out  1  high only in IDLE
- ext_we  in  1  register preload strobe, honoured only in IDLE
- ext_addr  in  4  preload address
- ext_data  in  16  preload data
- dbg_addr  in  4  debug read address
- dbg_data  out  16  combinational R[dbg_addr]
- alu_instruction  out  6  opcode to ALU
- alu_a  out  16  ALU operand A
- alu_b  out  16  ALU operand B
- alu_result  in  16  ALU combinational result
- done  out  1  one-cycle pulse when an instruction retires
- illegal  out  1  one-cycle pulse when an undefined opcode is consumed
- flag_z  out  1  last ADD/SUB/TEST result == 0
- flag_n  out  1  last ADD/SUB/TEST result bit 15

Behaviour:
- Opcodes: MOVE=3, NOT=4, AND=5, OR=6, SHIFTR=7, SHIFTL=8, ADD=9, SUB=10, TEST=11. All others are illegal.
- Reset values: all registers 0, state IDLE, flags 0, done/illegal 0. alu_instruction, alu_a and alu_b are 0 whenever not in EXEC/SHIFT.
- Reset mid-operation aborts immediately: no writeback, no done.
- States:
  - IDLE: instr_ready=1.
    - ext_we writes R[ext_addr] this edge.
    - On instr_valid the instruction is latched (op, rd, rs).
    - Legal opcode -> EXEC.
    - Illegal opcode -> illegal=1 next cycle; stay IDLE; instruction dropped.
    - ext_we and instr_valid in the same cycle: both take effect. EXEC reads the newly written value.
  - EXEC: alu_instruction=op, alu_a=R[rd], alu_b=R[rs].
    - Non-shift ops: R[rd]<=alu_result, except TEST, which writes nothing. ADD/SUB/TEST update flags. -> IDLE, done=1 next cycle.
    - SHIFTR/SHIFTL: cnt<=R[rs][3:0], acc<=R[rd]. cnt==0 -> IDLE with done, no write. Else -> SHIFT.
  - SHIFT: alu_instruction=op, alu_a=acc, alu_b=0.
    - Each cycle: acc<=alu_result, cnt<=cnt-1.
    - When cnt==1: R[rd]<=alu_result -> IDLE, done=1 next cycle.
- Latency (instruction accepted at edge T):
  - Non-shift: EXEC during T+1; result visible in R[rd] and done high at T+2.
  - Shift by n>=1: done at T+2+n.
  - Shift by 0: done at T+2.
- Shift count is latched in EXEC, so rs==rd is safe. Shift fill is 0; counts 1..15 only.
- Register arithmetic is modulo 2^16; no carry or overflow flags.
- Flags are untouched by MOVE, NOT, AND, OR and the shifts.
- Back-to-back issue: the next instruction can be accepted in the cycle done is high, since IDLE is re-entered.
- dbg_data is combinational and independent of state.

Decomposition:
- Shared package alu_pkg holds:
  - opcode constants (3..11), shared with the ALU;
  - instruction field positions;
  - state encoding IDLE/EXEC/SHIFT;
  - an is_legal/is_shift helper function.
- Sub-module alu_sequencer_regfile:
  - 16x16 array;
  - two combinational read ports (rd/rs plus dbg), one synchronous write port;
  - write mux (ext vs writeback) resolved in the parent.

Test Plan:
- Preload R1=0x0005, R2=0x0003; ADD rd=1 rs=2 -> alu_instruction=9 in EXEC; R1=0x0008 and done at T+2; Z=0, N=0.
- R3=0x0004, R4=0x0004; TEST rd=3 rs=4 -> Z=1, N=0; R3 still 0x0004. Then SUB with R4=0x0005 -> R3=0xFFFF, N=1, Z=0.
- R5=0x8001, R6=0x0003; SHIFTR rd=5 rs=6 -> 3 SHIFT cycles with alu_instruction=7; R5=0x1000; done at T+5; flags unchanged.
- SHIFTL rd=6 rs=6 with R6=0x0002 -> R6=0x0008 (count latched before write). Shift with count 0 -> done at T+2, no change.
- instr opcode 0x3F -> illegal pulse, no done, no register change, instr_ready stays 1. Opcode 0 -> likewise.
- Assert reset during the second SHIFT cycle of a 5-bit shift -> next cycle IDLE, all registers and flags 0, no done; a subsequent ADD completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its issue/writeback sequencer:
// opcodes, instruction field positions, sequencer states and decode helpers.
package alu_pkg;

    localparam int WIDTH = 16;
    localparam int NREGS = 16;
    localparam int AW    = 4;
    localparam int OPW   = 6;
    localparam int CNTW  = 4;

    localparam logic [OPW-1:0] OP_MOVE   = 6'd3;
    localparam logic [OPW-1:0] OP_NOT    = 6'd4;
    localparam logic [OPW-1:0] OP_AND    = 6'd5;
    localparam logic [OPW-1:0] OP_OR     = 6'd6;
    localparam logic [OPW-1:0] OP_SHIFTR = 6'd7;
    localparam logic [OPW-1:0] OP_SHIFTL = 6'd8;
    localparam logic [OPW-1:0] OP_ADD    = 6'd9;
    localparam logic [OPW-1:0] OP_SUB    = 6'd10;
    localparam logic [OPW-1:0] OP_TEST   = 6'd11;

    localparam int INSTR_OP_HI = 15;
    localparam int INSTR_OP_LO = 10;
    localparam int INSTR_RD_HI = 9;
    localparam int INSTR_RD_LO = 6;
    localparam int INSTR_RS_HI = 5;
    localparam int INSTR_RS_LO = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_SHIFT = 2'd2
    } seq_state_e;

    function automatic logic is_legal(input logic [OPW-1:0] op);
        return (op >= OP_MOVE) && (op <= OP_TEST);
    endfunction

    function automatic logic is_shift(input logic [OPW-1:0] op);
        return (op == OP_SHIFTR) || (op == OP_SHIFTL);
    endfunction

    function automatic logic updates_flags(input logic [OPW-1:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_TEST);
    endfunction

endpackage

// File: rtl/alu_sequencer_regfile.sv
// Register file for the ALU sequencer: three combinational read ports
// (operand A, operand B, debug) and one synchronous write port.
module alu_sequencer_regfile
    import alu_pkg::*;
#(
    parameter int P_WIDTH = 16,
    parameter int P_NREGS = 16,
    parameter int P_AW    = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_we,
    input  logic [P_AW-1:0]    i_waddr,
    input  logic [P_WIDTH-1:0] i_wdata,
    input  logic [P_AW-1:0]    i_raddr_a,
    output logic [P_WIDTH-1:0] o_rdata_a,
    input  logic [P_AW-1:0]    i_raddr_b,
    output logic [P_WIDTH-1:0] o_rdata_b,
    input  logic [P_AW-1:0]    i_raddr_dbg,
    output logic [P_WIDTH-1:0] o_rdata_dbg
);

    logic [P_WIDTH-1:0] r_mem [P_NREGS];

    // Storage array: cleared by reset, single write port otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < P_NREGS; i++) begin
                r_mem[i] <= {P_WIDTH{1'b0}};
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a   = r_mem[i_raddr_a];
    assign o_rdata_b   = r_mem[i_raddr_b];
    assign o_rdata_dbg = r_mem[i_raddr_dbg];

endmodule

// File: rtl/alu_sequencer.sv
// Multicycle issue/writeback controller for the 16-bit ALU: decodes an
// instruction, drives the ALU, writes back, and iterates single-bit shifts.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int NREGS = 16,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             instr_valid,
    input  logic [15:0]      instr,
    output logic             instr_ready,
    input  logic             ext_we,
    input  logic [AW-1:0]    ext_addr,
    input  logic [WIDTH-1:0] ext_data,
    input  logic [AW-1:0]    dbg_addr,
    output logic [WIDTH-1:0] dbg_data,
    output logic [OPW-1:0]   alu_instruction,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    output logic             done,
    output logic             illegal,
    output logic             flag_z,
    output logic             flag_n
);

    seq_state_e       r_state;
    seq_state_e       w_state_nxt;
    logic [OPW-1:0]   r_op;
    logic [AW-1:0]    r_rd;
    logic [AW-1:0]    r_rs;
    logic [CNTW-1:0]  r_cnt;
    logic [WIDTH-1:0] r_acc;
    logic             r_done;
    logic             r_illegal;
    logic             r_flag_z;
    logic             r_flag_n;

    logic [OPW-1:0]   w_op;
    logic [AW-1:0]    w_rd;
    logic [AW-1:0]    w_rs;
    logic [WIDTH-1:0] w_rd_data;
    logic [WIDTH-1:0] w_rs_data;
    logic             w_latch;
    logic             w_shift_load;
    logic             w_shift_step;
    logic             w_wb_en;
    logic             w_flags_en;
    logic             w_done_nxt;
    logic             w_illegal_nxt;
    logic [OPW-1:0]   w_alu_instr;
    logic [WIDTH-1:0] w_alu_a;
    logic [WIDTH-1:0] w_alu_b;
    logic             w_rf_we;
    logic [AW-1:0]    w_rf_waddr;
    logic [WIDTH-1:0] w_rf_wdata;
    logic             w_unused;

    assign w_op     = instr[INSTR_OP_HI:INSTR_OP_LO];
    assign w_rd     = instr[INSTR_RD_HI:INSTR_RD_LO];
    assign w_rs     = instr[INSTR_RS_HI:INSTR_RS_LO];
    assign w_unused = ^instr[1:0];

    // Writeback never happens in IDLE, so external preloads cannot collide with it.
    assign w_rf_we    = w_wb_en | (ext_we & (r_state == ST_IDLE));
    assign w_rf_waddr = w_wb_en ? r_rd : ext_addr;
    assign w_rf_wdata = w_wb_en ? alu_result : ext_data;

    alu_sequencer_regfile #(
        .P_WIDTH (WIDTH),
        .P_NREGS (NREGS),
        .P_AW    (AW)
    ) u_regfile (
        .clk         (clk),
        .reset       (reset),
        .i_we        (w_rf_we),
        .i_waddr     (w_rf_waddr),
        .i_wdata     (w_rf_wdata),
        .i_raddr_a   (r_rd),
        .o_rdata_a   (w_rd_data),
        .i_raddr_b   (r_rs),
        .o_rdata_b   (w_rs_data),
        .i_raddr_dbg (dbg_addr),
        .o_rdata_dbg (dbg_data)
    );

    // Next-state, ALU drive and writeback control.
    always_comb begin
        w_state_nxt   = r_state;
        w_latch       = 1'b0;
        w_shift_load  = 1'b0;
        w_shift_step  = 1'b0;
        w_wb_en       = 1'b0;
        w_flags_en    = 1'b0;
        w_done_nxt    = 1'b0;
        w_illegal_nxt = 1'b0;
        w_alu_instr   = {OPW{1'b0}};
        w_alu_a       = {WIDTH{1'b0}};
        w_alu_b       = {WIDTH{1'b0}};
        case (r_state)
            ST_IDLE: begin
                if (instr_valid) begin
                    if (is_legal(w_op)) begin
                        w_latch     = 1'b1;
                        w_state_nxt = ST_EXEC;
                    end else begin
                        w_illegal_nxt = 1'b1;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_EXEC: begin
                w_alu_instr = r_op;
                w_alu_a     = w_rd_data;
                w_alu_b     = w_rs_data;
                if (is_shift(r_op)) begin
                    // Count and seed are captured here, so rs == rd is harmless.
                    w_shift_load = 1'b1;
                    if (w_rs_data[CNTW-1:0] == {CNTW{1'b0}}) begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_SHIFT;
                    end
                end else begin
                    w_wb_en     = (r_op != OP_TEST);
                    w_flags_en  = updates_flags(r_op);
                    w_done_nxt  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                w_alu_instr  = r_op;
                w_alu_a      = r_acc;
                w_alu_b      = {WIDTH{1'b0}};
                w_shift_step = 1'b1;
                if (r_cnt == 4'd1) begin
                    w_wb_en     = 1'b1;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_SHIFT;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Sequencer state, latched instruction, shift iterator, pulses and flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_op      <= {OPW{1'b0}};
            r_rd      <= {AW{1'b0}};
            r_rs      <= {AW{1'b0}};
            r_cnt     <= {CNTW{1'b0}};
            r_acc     <= {WIDTH{1'b0}};
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
            r_flag_z  <= 1'b0;
            r_flag_n  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_done    <= w_done_nxt;
            r_illegal <= w_illegal_nxt;
            if (w_latch) begin
                r_op <= w_op;
                r_rd <= w_rd;
                r_rs <= w_rs;
            end
            if (w_shift_load) begin
                r_cnt <= w_rs_data[CNTW-1:0];
                r_acc <= w_rd_data;
            end else if (w_shift_step) begin
                r_cnt <= r_cnt - 4'd1;
                r_acc <= alu_result;
            end
            if (w_flags_en) begin
                r_flag_z <= (alu_result == {WIDTH{1'b0}});
                r_flag_n <= alu_result[WIDTH-1];
            end
        end
    end

    assign instr_ready     = (r_state == ST_IDLE);
    assign alu_instruction = w_alu_instr;
    assign alu_a           = w_alu_a;
    assign alu_b           = w_alu_b;
    assign done            = r_done;
    assign illegal         = r_illegal;
    assign flag_z          = r_flag_z;
    assign flag_n          = r_flag_n;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural ALU attached to its
// operand/result interface; table-driven vectors plus multi-cycle sequences.
module tb_alu_sequencer;

    logic        clk;
    logic        reset;
    logic        instr_valid;
    logic [15:0] instr;
    logic        instr_ready;
    logic        ext_we;
    logic [3:0]  ext_addr;
    logic [15:0] ext_data;
    logic [3:0]  dbg_addr;
    logic [15:0] dbg_data;
    logic [5:0]  alu_instruction;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [15:0] alu_result;
    logic        done;
    logic        illegal;
    logic        flag_z;
    logic        flag_n;

    int n_tests = 0;
    int n_fail  = 0;

    alu_sequencer dut (
        .clk             (clk),
        .reset           (reset),
        .instr_valid     (instr_valid),
        .instr           (instr),
        .instr_ready     (instr_ready),
        .ext_we          (ext_we),
        .ext_addr        (ext_addr),
        .ext_data        (ext_data),
        .dbg_addr        (dbg_addr),
        .dbg_data        (dbg_data),
        .alu_instruction (alu_instruction),
        .alu_a           (alu_a),
        .alu_b           (alu_b),
        .alu_result      (alu_result),
        .done            (done),
        .illegal         (illegal),
        .flag_z          (flag_z),
        .flag_n          (flag_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU.
    always_comb begin
        case (alu_instruction)
            6'd3:    alu_result = alu_b;
            6'd4:    alu_result = ~alu_a;
            6'd5:    alu_result = alu_a & alu_b;
            6'd6:    alu_result = alu_a | alu_b;
            6'd7:    alu_result = alu_a >> 1;
            6'd8:    alu_result = alu_a << 1;
            6'd9:    alu_result = alu_a + alu_b;
            6'd10:   alu_result = alu_a - alu_b;
            6'd11:   alu_result = alu_a - alu_b;
            default: alu_result = 16'h0000;
        endcase
    end

    typedef struct {
        logic [5:0]  op;
        logic [3:0]  rd;
        logic [3:0]  rs;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp;
        logic        z;
        logic        n;
        int          shifts;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [3:0] addr, input logic [15:0] data);
        ext_we   = 1'b1;
        ext_addr = addr;
        ext_data = data;
        tick();
        ext_we   = 1'b0;
    endtask

    task automatic read_reg(input logic [3:0] addr, output logic [15:0] data);
        dbg_addr = addr;
        #1;
        data = dbg_data;
    endtask

    // Offer an instruction, let it be accepted, leave the bench in the EXEC cycle.
    task automatic issue(input logic [5:0] op, input logic [3:0] rd, input logic [3:0] rs);
        instr       = {op, rd, rs, 2'b00};
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        instr       = 16'h0000;
    endtask

    // From the EXEC cycle, count edges until done; also count SHIFT cycles seen.
    task automatic wait_done(input logic [5:0] op, output int edges, output int shifts);
        edges  = 0;
        shifts = 0;
        do begin
            tick();
            edges++;
            if (!done && alu_instruction == op && alu_b == 16'h0000) shifts++;
        end while (!done && edges < 40);
    endtask

    logic [15:0] rv;
    int          edges;
    int          shifts;

    initial begin
        reset       = 1'b1;
        instr_valid = 1'b0;
        instr       = 16'h0000;
        ext_we      = 1'b0;
        ext_addr    = 4'h0;
        ext_data    = 16'h0000;
        dbg_addr    = 4'h0;

        //           op     rd    rs    a         b         exp       z     n     shifts
        vecs[0]  = '{6'd9,  4'd1, 4'd2, 16'h0005, 16'h0003, 16'h0008, 1'b0, 1'b0, 0};
        vecs[1]  = '{6'd11, 4'd3, 4'd4, 16'h0004, 16'h0004, 16'h0004, 1'b1, 1'b0, 0};
        vecs[2]  = '{6'd10, 4'd3, 4'd4, 16'h0004, 16'h0005, 16'hFFFF, 1'b0, 1'b1, 0};
        vecs[3]  = '{6'd7,  4'd5, 4'd6, 16'h8001, 16'h0003, 16'h1000, 1'b0, 1'b1, 3};
        vecs[4]  = '{6'd5,  4'd7, 4'd8, 16'hF0F0, 16'h3C3C, 16'h3030, 1'b0, 1'b1, 0};
        vecs[5]  = '{6'd6,  4'd7, 4'd8, 16'hF0F0, 16'h0F0F, 16'hFFFF, 1'b0, 1'b1, 0};
        vecs[6]  = '{6'd4,  4'd9, 4'd10, 16'h1234, 16'h0000, 16'hEDCB, 1'b0, 1'b1, 0};
        vecs[7]  = '{6'd3,  4'd9, 4'd10, 16'h0000, 16'hBEEF, 16'hBEEF, 1'b0, 1'b1, 0};
        vecs[8]  = '{6'd9,  4'd11, 4'd12, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 0};
        vecs[9]  = '{6'd8,  4'd13, 4'd14, 16'h0001, 16'h000F, 16'h8000, 1'b1, 1'b0, 15};
        vecs[10] = '{6'd10, 4'd1, 4'd2, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b1, 0};

        tick();
        tick();
        reset = 1'b0;

        check("reset_ready", {31'd0, instr_ready}, 32'd1);
        check("reset_done", {30'd0, done, illegal}, 32'd0);
        check("reset_flags", {30'd0, flag_z, flag_n}, 32'd0);
        check("reset_alu", {alu_instruction, alu_a[9:0], alu_b}, 32'd0);
        read_reg(4'd1, rv);
        check("reset_r1", {16'd0, rv}, 32'd0);
        read_reg(4'd15, rv);
        check("reset_r15", {16'd0, rv}, 32'd0);

        for (int i = 0; i < 11; i++) begin
            preload(vecs[i].rd, vecs[i].a);
            preload(vecs[i].rs, vecs[i].b);
            issue(vecs[i].op, vecs[i].rd, vecs[i].rs);
            check($sformatf("v%0d_exec_op", i), {26'd0, alu_instruction}, {26'd0, vecs[i].op});
            check($sformatf("v%0d_exec_ab", i), {alu_a, alu_b}, {vecs[i].a, vecs[i].b});
            check($sformatf("v%0d_ready_busy", i), {31'd0, instr_ready}, 32'd0);
            wait_done(vecs[i].op, edges, shifts);
            check($sformatf("v%0d_latency", i), edges, vecs[i].shifts + 1);
            check($sformatf("v%0d_shift_cycles", i), shifts, vecs[i].shifts);
            read_reg(vecs[i].rd, rv);
            check($sformatf("v%0d_result", i), {16'd0, rv}, {16'd0, vecs[i].exp});
            check($sformatf("v%0d_flags", i), {30'd0, flag_z, flag_n}, {30'd0, vecs[i].z, vecs[i].n});
        end

        // SHIFTL with rs == rd: count is taken before the result is written.
        preload(4'd6, 16'h0002);
        issue(6'd8, 4'd6, 4'd6);
        wait_done(6'd8, edges, shifts);
        check("shl_self_latency", edges, 3);
        read_reg(4'd6, rv);
        check("shl_self_result", {16'd0, rv}, 32'h0000_0008);

        // Shift by zero: retires straight from EXEC with no write.
        preload(4'd5, 16'h1234);
        preload(4'd0, 16'h0010);
        issue(6'd7, 4'd5, 4'd0);
        wait_done(6'd7, edges, shifts);
        check("shr0_latency", edges, 1);
        check("shr0_shift_cycles", shifts, 0);
        read_reg(4'd5, rv);
        check("shr0_unchanged", {16'd0, rv}, 32'h0000_1234);
        check("shr0_flags", {30'd0, flag_z, flag_n}, 32'd1);

        // Illegal opcodes 0x3F and 0x00.
        for (int k = 0; k < 2; k++) begin
            logic [5:0] bad;
            bad = (k == 0) ? 6'h3F : 6'h00;
            issue(bad, 4'd5, 4'd0);
            check($sformatf("ill%0d_pulse", k), {29'd0, illegal, done, instr_ready}, 32'd5);
            tick();
            check($sformatf("ill%0d_clear", k), {29'd0, illegal, done, instr_ready}, 32'd1);
            tick();
            check($sformatf("ill%0d_nodone", k), {31'd0, done}, 32'd0);
            read_reg(4'd5, rv);
            check($sformatf("ill%0d_reg", k), {16'd0, rv}, 32'h0000_1234);
        end

        // Preload and issue in the same cycle: EXEC sees the new operand.
        preload(4'd1, 16'h0001);
        ext_we   = 1'b1;
        ext_addr = 4'd2;
        ext_data = 16'h0100;
        issue(6'd9, 4'd1, 4'd2);
        ext_we = 1'b0;
        check("same_cycle_b", {16'd0, alu_b}, 32'h0000_0100);
        wait_done(6'd9, edges, shifts);
        read_reg(4'd1, rv);
        check("same_cycle_result", {16'd0, rv}, 32'h0000_0101);

        // Reset during the second SHIFT cycle of a 5-bit shift.
        preload(4'd7, 16'hFFFF);
        preload(4'd8, 16'h0005);
        issue(6'd8, 4'd7, 4'd8);
        tick();
        tick();
        check("abort_in_shift", {26'd0, alu_instruction}, 32'd8);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_state", {29'd0, instr_ready, done, illegal}, 32'd4);
        check("abort_flags", {30'd0, flag_z, flag_n}, 32'd0);
        check("abort_alu", {26'd0, alu_instruction}, 32'd0);
        read_reg(4'd7, rv);
        check("abort_r7", {16'd0, rv}, 32'd0);
        read_reg(4'd8, rv);
        check("abort_r8", {16'd0, rv}, 32'd0);
        tick();
        check("abort_nodone", {31'd0, done}, 32'd0);

        preload(4'd1, 16'h0002);
        preload(4'd2, 16'h0003);
        issue(6'd9, 4'd1, 4'd2);
        wait_done(6'd9, edges, shifts);
        check("post_abort_latency", edges, 1);
        read_reg(4'd1, rv);
        check("post_abort_result", {16'd0, rv}, 32'h0000_0005);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
